// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: N-channel cache-miss arbiter with one-deep per-channel slots,
// fixed-priority or round-robin grant, request-latency delay and tagged response.
module mem_req_arbiter #(
   parameter int NUM_CH    = 2,
   parameter int ADDR_W    = 32,
   parameter int LINE_W    = 128,
   parameter int LAT_REQ   = 4,
   parameter int PRIO_MODE = 0,
   localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NUM_CH-1:0]          req_valid_i,
   input  logic [NUM_CH-1:0]          req_is_store_i,
   input  logic [NUM_CH*ADDR_W-1:0]   req_addr_i,
   input  logic [NUM_CH*LINE_W-1:0]   req_data_i,
   output logic [NUM_CH-1:0]          req_busy_o,
   output logic [NUM_CH-1:0]          req_overrun_o,
   output logic                       mm_req_valid_o,
   output logic                       mm_req_is_store_o,
   output logic [ADDR_W-1:0]          mm_req_addr_o,
   output logic [LINE_W-1:0]          mm_req_data_o,
   input  logic                       mm_rsp_valid_i,
   input  logic [LINE_W-1:0]          mm_rsp_data_i,
   input  logic                       mm_rsp_bus_error_i,
   output logic                       rsp_valid_o,
   output logic [CH_W-1:0]            rsp_ch_id_o,
   output logic [LINE_W-1:0]          rsp_data_o,
   output logic                       rsp_bus_error_o
);
   localparam int CNT_W = (LAT_REQ > 1) ? $clog2(LAT_REQ) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((LAT_REQ > 0) ? LAT_REQ - 1 : 0);
   typedef enum logic [1:0] {IDLE, WAIT, ISSUE} state_t;
   state_t state, state_nx;
   logic [NUM_CH-1:0] busy, slot_st, release_ch;
   logic [ADDR_W-1:0] slot_addr [NUM_CH];
   logic [LINE_W-1:0] slot_data [NUM_CH];
   logic [CH_W-1:0] grant_idx, last_grant, win;
   logic grant_st, found, rsp_fire, grant_fire;
   logic [ADDR_W-1:0] grant_addr;
   logic [LINE_W-1:0] grant_data;
   logic [CNT_W-1:0] cnt;
   int pick;
   assign rsp_fire          = (state == ISSUE) && mm_rsp_valid_i;
   assign grant_fire        = (state == IDLE) && (|busy);
   assign req_busy_o        = busy;
   assign mm_req_valid_o    = (state == ISSUE);
   assign mm_req_is_store_o = grant_st;
   assign mm_req_addr_o     = grant_addr;
   assign mm_req_data_o     = grant_data;
   always_comb begin
      release_ch = '0;
      for (int k = 0; k < NUM_CH; k++)
         release_ch[k] = rsp_fire && (grant_idx == CH_W'(k));
   end
   // Walk candidates in priority order: descending index, or rotating from last_grant+1.
   always_comb begin
      win   = '0;
      found = 1'b0;
      pick  = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         pick = (PRIO_MODE != 0) ? (int'(last_grant) + 1 + i) % NUM_CH : NUM_CH - 1 - i;
         if (!found && busy[pick]) begin
            win   = CH_W'(pick);
            found = 1'b1;
         end
      end
   end
   // A slot being released this cycle may accept a new request without an overrun.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         busy          <= '0;
         slot_st       <= '0;
         req_overrun_o <= '0;
         for (int k = 0; k < NUM_CH; k++) begin
            slot_addr[k] <= '0;
            slot_data[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            req_overrun_o[k] <= req_valid_i[k] && busy[k] && !release_ch[k];
            if (req_valid_i[k] && (!busy[k] || release_ch[k])) begin
               busy[k]      <= 1'b1;
               slot_st[k]   <= req_is_store_i[k];
               slot_addr[k] <= req_addr_i[k*ADDR_W +: ADDR_W];
               slot_data[k] <= req_data_i[k*LINE_W +: LINE_W];
            end else if (release_ch[k]) begin
               busy[k] <= 1'b0;
            end
         end
      end
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      if (grant_fire) state_nx = (LAT_REQ == 0) ? ISSUE : WAIT;
      if ((state == WAIT) && (cnt == CNT_LAST)) state_nx = ISSUE;
      if (rsp_fire) state_nx = IDLE;
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         grant_idx       <= '0;
         last_grant      <= CH_W'(NUM_CH - 1);
         grant_st        <= 1'b0;
         grant_addr      <= '0;
         grant_data      <= '0;
         cnt             <= '0;
         rsp_valid_o     <= 1'b0;
         rsp_ch_id_o     <= '0;
         rsp_data_o      <= '0;
         rsp_bus_error_o <= 1'b0;
      end else begin
         rsp_valid_o <= rsp_fire;
         if (grant_fire) begin
            grant_idx  <= win;
            last_grant <= win;
            grant_st   <= slot_st[win];
            grant_addr <= slot_addr[win];
            grant_data <= slot_data[win];
            cnt        <= '0;
         end
         if (state == WAIT) cnt <= cnt + 1'b1;
         if (rsp_fire) begin
            rsp_ch_id_o     <= grant_idx;
            rsp_data_o      <= mm_rsp_data_i;
            rsp_bus_error_o <= mm_rsp_bus_error_i;
         end
      end
   end
endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Parametrised N-channel miss arbiter between the core's cache miss ports and the main-memory model. It generalises the two-port I$/D$ arbitration into NUM_CH channels, and gives each channel a one-deep pending slot. It supports fixed-priority or round-robin arbitration, a configurable request-latency counter, and a registered, channel-tagged response with bus-error passthrough. It sits between core_top's miss interfaces and the main-memory model, in the core bench and in future multi-requester SoC builds.

## Interface
- NUM_CH, 2: number of requesting channels (>=1); ch0 = I$, ch1 = D$ in the core build.
- ADDR_W, 32: request address width.
- LINE_W, 128: cache-line data width.
- LAT_REQ, 4: cycles spent in WAIT between grant and memory issue (0 allowed).
- PRIO_MODE, 0: 0 = fixed priority, highest index wins; 1 = round-robin.
- CH_W (local): max(1, $clog2(NUM_CH)).

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req_valid_i  in  NUM_CH  one-cycle request pulse per channel.
- req_is_store_i  in  NUM_CH  1 = store, 0 = load.
- req_addr_i  in  NUM_CH*ADDR_W  per-channel address; channel k occupies bits [k*ADDR_W +: ADDR_W].
- req_data_i  in  NUM_CH*LINE_W  per-channel store data.
- req_busy_o  out  NUM_CH  channel slot holds an unserved request.
- req_overrun_o  out  NUM_CH  one-cycle pulse when a request is dropped because the slot is full.
- mm_req_valid_o  out  1  request to memory; held until a response arrives.
- mm_req_is_store_o  out  1; mm_req_addr_o  out  ADDR_W; mm_req_data_o  out  LINE_W  granted request fields; stable while mm_req_valid_o is high.
- mm_rsp_valid_i  in  1; mm_rsp_data_i  in  LINE_W; mm_rsp_bus_error_i  in  1  memory response.
- rsp_valid_o  out  1  one-cycle response pulse to the core.
- rsp_ch_id_o  out  CH_W  destination channel.
- rsp_data_o  out  LINE_W; rsp_bus_error_o  out  1  response payload.

## Operation
- Per-channel slot: req_valid_i[k] with slot k empty captures is_store, addr and data, and sets req_busy_o[k].
- req_valid_i[k] with slot k full drops the request and pulses req_overrun_o[k].
  - Exception: if slot k is being released in the same cycle (its response is being registered), the new request is captured and req_busy_o[k] stays 1.
- FSM states: IDLE, WAIT, ISSUE.
- IDLE:
  - If any slot is busy, select a winner, latch its fields and index into grant registers, and clear the counter.
  - Next state is WAIT, or ISSUE directly when LAT_REQ = 0.
  - The grant sees only slots already busy at the clock edge; a same-cycle req_valid_i is not eligible.
- WAIT: the counter increments each cycle; on counter = LAT_REQ-1, next state is ISSUE.
- ISSUE:
  - mm_req_valid_o = 1 and the mm_req_* fields come from the grant registers.
  - When mm_rsp_valid_i is sampled high, at the next edge:
    - register rsp_valid_o = 1, rsp_ch_id_o = grant index, rsp_data_o = mm_rsp_data_i, rsp_bus_error_o = mm_rsp_bus_error_i;
    - clear the granted slot;
    - go to IDLE (mm_req_valid_o = 0).
- mm_rsp_valid_i outside ISSUE is ignored.
- Fixed priority: highest busy index wins.
- Round-robin:
  - last_grant pointer resets to NUM_CH-1.
  - The search starts at last_grant+1 and wraps modulo NUM_CH.
  - The pointer updates on each grant.
- rsp_data_o and rsp_bus_error_o hold their value between pulses; only rsp_valid_o qualifies them.

## Timing
- Reset values: every output is 0; FSM = IDLE; all slots empty; counter = 0; last_grant = NUM_CH-1.
- Reset mid-operation: the in-flight request and all pending slots are discarded; no response is produced for them.
- Request pulse at cycle t (slot empty, FSM idle):
  - req_busy_o = 1 at t+1;
  - grant at the end of t+1;
  - mm_req_valid_o = 1 from t+2+LAT_REQ.
- mm_rsp_valid_i high at cycle r → rsp_valid_o = 1 and req_busy_o[k] = 0 at r+1; mm_req_valid_o = 0 at r+1.
- The earliest next grant is at the end of r+1, so back-to-back services are spaced by LAT_REQ + 2 cycles plus the memory latency.
- Overrun pulse appears one cycle after the dropped req_valid_i.

## Test plan
- NUM_CH=2, LAT_REQ=4, PRIO_MODE=0; ch1 load addr 0x40 at cycle 0; memory answers 3 cycles after mm_req_valid_o → mm_req_valid_o rises at cycle 6, rsp_valid_o at cycle 10 with ch_id=1, data echoed, req_busy_o[1] falls at cycle 10.
- Fixed priority: ch0 and ch1 requested in the same cycle → ch1 is served first, then ch0; exactly two rsp_valid_o pulses, in order 1, 0.
- NUM_CH=4, PRIO_MODE=1: all four channels requested together, then each re-requested on its own response → grants in order 0,1,2,3,0,1,... and no channel is granted twice in a row while others are waiting.
- Overrun: ch0 requested twice before service → req_overrun_o[0] pulses once and only the first addr reaches memory. Re-request in the response cycle → captured, no overrun.
- LAT_REQ=0 and mm_rsp_bus_error_i=1 → mm_req_valid_o at t+2; rsp_bus_error_o=1 with rsp_valid_o.
- Reset asserted during ISSUE → mm_req_valid_o, req_busy_o and rsp_valid_o are 0 immediately. A late mm_rsp_valid_i after release produces no response.
